// File: rtl/seg_decode_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the digit count, the segment bit positions on the segment bus and the
// active-high 7-bit pattern for each hex glyph (bit 0 = segment a).
package seg_decode_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] PAT_0 = 7'h3F;
  localparam logic [6:0] PAT_1 = 7'h06;
  localparam logic [6:0] PAT_2 = 7'h5B;
  localparam logic [6:0] PAT_3 = 7'h4F;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h6D;
  localparam logic [6:0] PAT_6 = 7'h7D;
  localparam logic [6:0] PAT_7 = 7'h07;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h6F;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h7C;
  localparam logic [6:0] PAT_C = 7'h39;
  localparam logic [6:0] PAT_D = 7'h5E;
  localparam logic [6:0] PAT_E = 7'h79;
  localparam logic [6:0] PAT_F = 7'h71;

endpackage

// File: rtl/segment_hex_decoder.sv
// Combinational inverse of the hex-to-seven-segment encoder.
// Ports:
//   pattern_i  active-high segments a-g (bit 0 = a)
//   nibble_o   recovered hex value (0 when there is no match)
//   match_o    high when pattern_i is one of the sixteen hex glyphs
module segment_hex_decoder
  import seg_decode_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       match_o
);

  // A blank pattern (all segments off) is not a glyph and falls to the default.
  always_comb begin
    nibble_o = 4'h0;
    match_o  = 1'b1;
    case (pattern_i)
      PAT_0:   nibble_o = 4'h0;
      PAT_1:   nibble_o = 4'h1;
      PAT_2:   nibble_o = 4'h2;
      PAT_3:   nibble_o = 4'h3;
      PAT_4:   nibble_o = 4'h4;
      PAT_5:   nibble_o = 4'h5;
      PAT_6:   nibble_o = 4'h6;
      PAT_7:   nibble_o = 4'h7;
      PAT_8:   nibble_o = 4'h8;
      PAT_9:   nibble_o = 4'h9;
      PAT_A:   nibble_o = 4'hA;
      PAT_B:   nibble_o = 4'hB;
      PAT_C:   nibble_o = 4'hC;
      PAT_D:   nibble_o = 4'hD;
      PAT_E:   nibble_o = 4'hE;
      PAT_F:   nibble_o = 4'hF;
      default: match_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Watches a multiplexed four-digit seven-segment bus and recovers the digits
// being shown. A (select, segment) pair is captured once it has been stable
// for SETTLE cycles; once all four digits have been captured the frame is
// published on digits_o/dps_o with a one-cycle frame_valid_o strobe.
// Ports:
//   clk_i, rst_ni      clock and asynchronous active-low reset
//   seg_select_i       digit strobes, bit k selects digit k
//   seg_write_i        segments a-g in bits 0-6, decimal point in bit 7
//   err_clear_i        clears the sticky error flags
//   digits_o           last frame, digit0 in [15:12] .. digit3 in [3:0]
//   dps_o              decimal point of digit k in bit k
//   frame_valid_o      pulse when digits_o/dps_o update
//   changed_o          pulse with frame_valid_o when the digits differ
//   stale_o            no successful capture for TIMEOUT cycles
//   err_pattern_o      sticky: captured pattern was not a hex glyph
//   err_select_o       sticky: several digits selected in a stable window
module segment_scan_decoder
  import seg_decode_pkg::*;
#(
  parameter int SETTLE         = 4,
  parameter int TIMEOUT        = 1000000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  seg_select_i,
  input  logic [7:0]  seg_write_i,
  input  logic        err_clear_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dps_o,
  output logic        frame_valid_o,
  output logic        changed_o,
  output logic        stale_o,
  output logic        err_pattern_o,
  output logic        err_select_o
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIME_MAX    = TW'(TIMEOUT);
  // Input registers reset to the bus idle level so release does not look busy.
  localparam logic [3:0] SEL_IDLE = {4{SEL_ACTIVE_LOW}};
  localparam logic [7:0] SEG_IDLE = {8{SEG_ACTIVE_LOW}};

  logic [3:0]    selRaw_q, selPrev_q;
  logic [7:0]    segRaw_q, segPrev_q;
  logic [SW-1:0] settleCnt_q, settleCnt_d;
  logic [TW-1:0] timeoutCnt_q, timeoutCnt_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   digitBuf_q, digitBuf_d;
  logic [3:0]    dpBuf_q, dpBuf_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dps_q, dps_d;
  logic          frameValid_q, frameValid_d;
  logic          changed_q, changed_d;
  logic          stale_q, stale_d;
  logic          errPattern_q, errPattern_d;
  logic          errSelect_q, errSelect_d;

  logic [3:0] selNorm;
  logic [7:0] segNorm;
  logic       pairChanged;
  logic       captureEvt;
  logic       oneSel;
  logic       multiSel;
  logic       capOk;
  logic [3:0] nibble;
  logic       match;

  assign selNorm     = selRaw_q ^ {4{SEL_ACTIVE_LOW}};
  assign segNorm     = segRaw_q ^ {8{SEG_ACTIVE_LOW}};
  assign pairChanged = (selRaw_q != selPrev_q) || (segRaw_q != segPrev_q);
  // Fires only on the count's step into SETTLE, once per stable window.
  assign captureEvt  = !pairChanged && (settleCnt_q == SETTLE_LAST);
  assign multiSel    = |(selNorm & (selNorm - 4'd1));
  assign oneSel      = (selNorm != 4'h0) && !multiSel;
  assign capOk       = captureEvt && oneSel && match;

  segment_hex_decoder u_hexDecoder (
    .pattern_i (segNorm[SEG_G:SEG_A]),
    .nibble_o  (nibble),
    .match_o   (match)
  );

  always_comb begin
    settleCnt_d  = settleCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    seen_d       = seen_q;
    digitBuf_d   = digitBuf_q;
    dpBuf_d      = dpBuf_q;
    digits_d     = digits_q;
    dps_d        = dps_q;
    frameValid_d = 1'b0;
    changed_d    = 1'b0;
    errPattern_d = errPattern_q;
    errSelect_d  = errSelect_q;

    if (pairChanged) begin
      settleCnt_d = '0;
    end else if (settleCnt_q != SETTLE_MAX) begin
      settleCnt_d = settleCnt_q + 1'b1;
    end

    // Publish the completed frame; the buffers still hold it this cycle.
    if (seen_q == 4'hF) begin
      digits_d     = digitBuf_q;
      dps_d        = dpBuf_q;
      frameValid_d = 1'b1;
      changed_d    = (digitBuf_q != digits_q);
      seen_d       = 4'h0;
    end

    if (timeoutCnt_q == TIME_MAX) begin
      seen_d = 4'h0;
    end

    // Applied after the clears above so a capture here seeds the next frame.
    if (capOk) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (selNorm[k]) begin
          digitBuf_d[4*(NUM_DIGITS-1-k) +: 4] = nibble;
          dpBuf_d[k]                          = segNorm[SEG_DP];
          seen_d[k]                           = 1'b1;
        end
      end
    end

    if (capOk) begin
      timeoutCnt_d = '0;
    end else if (timeoutCnt_q != TIME_MAX) begin
      timeoutCnt_d = timeoutCnt_q + 1'b1;
    end
    stale_d = (timeoutCnt_d == TIME_MAX);

    // A new error event outranks a simultaneous clear.
    if (err_clear_i) begin
      errPattern_d = 1'b0;
      errSelect_d  = 1'b0;
    end
    if (captureEvt && multiSel) begin
      errSelect_d = 1'b1;
    end
    if (captureEvt && oneSel && !match) begin
      errPattern_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      selRaw_q     <= SEL_IDLE;
      selPrev_q    <= SEL_IDLE;
      segRaw_q     <= SEG_IDLE;
      segPrev_q    <= SEG_IDLE;
      settleCnt_q  <= '0;
      timeoutCnt_q <= '0;
      seen_q       <= 4'h0;
      digitBuf_q   <= 16'h0;
      dpBuf_q      <= 4'h0;
      digits_q     <= 16'h0;
      dps_q        <= 4'h0;
      frameValid_q <= 1'b0;
      changed_q    <= 1'b0;
      stale_q      <= 1'b0;
      errPattern_q <= 1'b0;
      errSelect_q  <= 1'b0;
    end else begin
      selRaw_q     <= seg_select_i;
      selPrev_q    <= selRaw_q;
      segRaw_q     <= seg_write_i;
      segPrev_q    <= segRaw_q;
      settleCnt_q  <= settleCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      seen_q       <= seen_d;
      digitBuf_q   <= digitBuf_d;
      dpBuf_q      <= dpBuf_d;
      digits_q     <= digits_d;
      dps_q        <= dps_d;
      frameValid_q <= frameValid_d;
      changed_q    <= changed_d;
      stale_q      <= stale_d;
      errPattern_q <= errPattern_d;
      errSelect_q  <= errSelect_d;
    end
  end

  assign digits_o      = digits_q;
  assign dps_o         = dps_q;
  assign frame_valid_o = frameValid_q;
  assign changed_o     = changed_q;
  assign stale_o       = stale_q;
  assign err_pattern_o = errPattern_q;
  assign err_select_o  = errSelect_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder with active-low buses, SETTLE=4 and
// a short TIMEOUT so the stale flag can be reached quickly.
module tb_segment_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  seg_select;
  logic [7:0]  seg_write;
  logic        err_clear;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic        frame_valid;
  logic        changed;
  logic        stale;
  logic        err_pattern;
  logic        err_select;

  int          nChecks;
  int          nFail;
  int          frameCount;
  int          frameStart;
  logic [15:0] lastDigits;
  logic [3:0]  lastDps;
  logic        lastChanged;

  segment_scan_decoder #(
    .SETTLE         (4),
    .TIMEOUT        (100),
    .SEL_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seg_select_i  (seg_select),
    .seg_write_i   (seg_write),
    .err_clear_i   (err_clear),
    .digits_o      (digits),
    .dps_o         (dps),
    .frame_valid_o (frame_valid),
    .changed_o     (changed),
    .stale_o       (stale),
    .err_pattern_o (err_pattern),
    .err_select_o  (err_select)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records every frame strobe and the values published with it.
  always @(negedge clk) begin
    if (frame_valid) begin
      frameCount  = frameCount + 1;
      lastDigits  = digits;
      lastDps     = dps;
      lastChanged = changed;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] seg,
                               input int cycles);
    seg_select = sel;
    seg_write  = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scanDigit(input int k, input logic [6:0] pat, input logic dp,
                           input int cycles);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << k;
    applyStimulus(~oneHot, ~{dp, pat}, cycles);
  endtask

  task automatic blankGap(input int cycles);
    applyStimulus(4'hF, 8'hFF, cycles);
  endtask

  initial begin
    nChecks     = 0;
    nFail       = 0;
    frameCount  = 0;
    lastDigits  = 16'h0;
    lastDps     = 4'h0;
    lastChanged = 1'b0;
    rst_n       = 1'b0;
    err_clear   = 1'b0;
    seg_select  = 4'hF;
    seg_write   = 8'hFF;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_digits", digits, 16'h0);
    checkOutput("rst_dps", {12'h0, dps}, 16'h0);
    checkOutput("rst_frame_valid", {15'h0, frame_valid}, 16'h0);
    checkOutput("rst_changed", {15'h0, changed}, 16'h0);
    checkOutput("rst_stale", {15'h0, stale}, 16'h0);
    checkOutput("rst_err_pattern", {15'h0, err_pattern}, 16'h0);
    checkOutput("rst_err_select", {15'h0, err_select}, 16'h0);
    rst_n = 1'b1;
    blankGap(4);

    $display("[TB] first scan 1234");
    frameStart = frameCount;
    scanDigit(0, 7'h06, 1'b0, 8);
    scanDigit(1, 7'h5B, 1'b0, 8);
    scanDigit(2, 7'h4F, 1'b0, 8);
    scanDigit(3, 7'h66, 1'b0, 8);
    blankGap(6);
    checkOutput("scan1_frames", 16'(frameCount - frameStart), 16'd1);
    checkOutput("scan1_digits", lastDigits, 16'h1234);
    checkOutput("scan1_dps", {12'h0, lastDps}, 16'h0);
    checkOutput("scan1_changed", {15'h0, lastChanged}, 16'h1);

    $display("[TB] repeated scan 1234");
    frameStart = frameCount;
    scanDigit(0, 7'h06, 1'b0, 8);
    scanDigit(1, 7'h5B, 1'b0, 8);
    scanDigit(2, 7'h4F, 1'b0, 8);
    scanDigit(3, 7'h66, 1'b0, 8);
    blankGap(6);
    checkOutput("scan2_frames", 16'(frameCount - frameStart), 16'd1);
    checkOutput("scan2_digits", lastDigits, 16'h1234);
    checkOutput("scan2_changed", {15'h0, lastChanged}, 16'h0);

    $display("[TB] short holds never capture");
    frameStart = frameCount;
    for (int r = 0; r < 12; r++) begin
      scanDigit(0, 7'h6D, 1'b0, 3);
      scanDigit(1, 7'h7D, 1'b0, 3);
      scanDigit(2, 7'h07, 1'b0, 3);
      scanDigit(3, 7'h7F, 1'b0, 3);
    end
    checkOutput("short_frames", 16'(frameCount - frameStart), 16'd0);
    checkOutput("short_stale", {15'h0, stale}, 16'h1);
    checkOutput("short_digits", digits, 16'h1234);

    $display("[TB] two digits selected");
    frameStart = frameCount;
    applyStimulus(4'b0011, ~8'h06, 8);
    checkOutput("multi_err_select", {15'h0, err_select}, 16'h1);
    blankGap(10);
    checkOutput("multi_sticky", {15'h0, err_select}, 16'h1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    @(negedge clk);
    checkOutput("multi_cleared", {15'h0, err_select}, 16'h0);
    checkOutput("multi_err_pattern", {15'h0, err_pattern}, 16'h0);
    checkOutput("multi_frames", 16'(frameCount - frameStart), 16'd0);

    $display("[TB] bad pattern then scan AbCd");
    frameStart = frameCount;
    scanDigit(2, 7'h49, 1'b0, 8);
    blankGap(4);
    checkOutput("bad_err_pattern", {15'h0, err_pattern}, 16'h1);
    checkOutput("bad_frames", 16'(frameCount - frameStart), 16'd0);
    checkOutput("bad_err_select", {15'h0, err_select}, 16'h0);
    scanDigit(0, 7'h77, 1'b1, 8);
    scanDigit(1, 7'h7C, 1'b0, 8);
    scanDigit(2, 7'h39, 1'b0, 8);
    scanDigit(3, 7'h5E, 1'b0, 8);
    blankGap(6);
    checkOutput("abcd_frames", 16'(frameCount - frameStart), 16'd1);
    checkOutput("abcd_digits", lastDigits, 16'hABCD);
    checkOutput("abcd_dps", {12'h0, lastDps}, 16'h0001);
    checkOutput("abcd_changed", {15'h0, lastChanged}, 16'h1);
    checkOutput("abcd_stale", {15'h0, stale}, 16'h0);
    checkOutput("abcd_err_pattern", {15'h0, err_pattern}, 16'h1);

    $display("[TB] reset mid-frame");
    scanDigit(0, 7'h06, 1'b0, 8);
    scanDigit(1, 7'h5B, 1'b0, 8);
    scanDigit(2, 7'h4F, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_digits", digits, 16'h0);
    checkOutput("midrst_dps", {12'h0, dps}, 16'h0);
    checkOutput("midrst_err_pattern", {15'h0, err_pattern}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frameStart = frameCount;
    scanDigit(0, 7'h6D, 1'b0, 8);
    scanDigit(1, 7'h7D, 1'b0, 8);
    scanDigit(2, 7'h07, 1'b0, 8);
    scanDigit(3, 7'h7F, 1'b0, 8);
    blankGap(6);
    checkOutput("post_frames", 16'(frameCount - frameStart), 16'd1);
    checkOutput("post_digits", lastDigits, 16'h5678);
    checkOutput("post_dps", {12'h0, lastDps}, 16'h0);
    checkOutput("post_changed", {15'h0, lastChanged}, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
